// File: rtl/fpm_pkg.sv
// rtl/fpm_pkg.sv - shared widths and stage state encoding for the vector FP multiplier pipeline
package fpm_pkg;

    localparam int FPM_EXP_W  = 9;
    localparam int FPM_MANT_W = 48;
    localparam int FPM_LANES  = 4;

    // Encoding doubles as the held-beat count, so occupancy is the state itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } fpm_stage_state_t;

endpackage

// File: rtl/fpm_lane_mask.sv
// rtl/fpm_lane_mask.sv - zeroes one lane's payload when the lane is inactive
// Ports: active (lane mask bit), sign/exp/mant/ov in, *_m masked copies out. Combinational.
module fpm_lane_mask
    import fpm_pkg::*;
#(
    parameter int EXP_W  = FPM_EXP_W,
    parameter int MANT_W = FPM_MANT_W
) (
    input  logic              active,
    input  logic              sign,
    input  logic [EXP_W-1:0]  exp,
    input  logic [MANT_W-1:0] mant,
    input  logic              ov,
    output logic              sign_m,
    output logic [EXP_W-1:0]  exp_m,
    output logic [MANT_W-1:0] mant_m,
    output logic              ov_m
);

    assign sign_m = sign & active;
    assign exp_m  = active ? exp : '0;
    assign mant_m = active ? mant : '0;
    assign ov_m   = ov & active;

endmodule

// File: rtl/fpm_pipe_stage.sv
// rtl/fpm_pipe_stage.sv - elastic 2-entry skid pipeline register for FP multiplier lanes
// Ports: clk, reset (async, active-low), in_valid/in_ready + in_mask/sign/exp/mant/ov upstream,
// out_valid/out_ready + out_mask/sign/exp/mant/ov downstream, occupancy (held beats).
// FPM_PIPE_FLUSH_EN adds a synchronous active-high flush input that empties the stage.
module fpm_pipe_stage
    import fpm_pkg::*;
#(
    parameter int LANES  = FPM_LANES,
    parameter int EXP_W  = FPM_EXP_W,
    parameter int MANT_W = FPM_MANT_W
) (
    input  logic                    clk,
    input  logic                    reset,
`ifdef FPM_PIPE_FLUSH_EN
    input  logic                    flush,
`endif
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES-1:0]        in_mask,
    input  logic [LANES-1:0]        in_sign,
    input  logic [LANES*EXP_W-1:0]  in_exp,
    input  logic [LANES*MANT_W-1:0] in_mant,
    input  logic [LANES-1:0]        in_ov,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES-1:0]        out_mask,
    output logic [LANES-1:0]        out_sign,
    output logic [LANES*EXP_W-1:0]  out_exp,
    output logic [LANES*MANT_W-1:0] out_mant,
    output logic [LANES-1:0]        out_ov,
    output logic [1:0]              occupancy
);

    // Whole beat flattened as {mask, sign, ov, exp, mant} so main/skid moves are one vector.
    localparam int PAY_W = 3*LANES + LANES*EXP_W + LANES*MANT_W;

    logic [LANES-1:0]        cap_sign;
    logic [LANES-1:0]        cap_ov;
    logic [LANES*EXP_W-1:0]  cap_exp;
    logic [LANES*MANT_W-1:0] cap_mant;
    logic [PAY_W-1:0]        cap_pay;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        fpm_lane_mask #(
            .EXP_W  (EXP_W),
            .MANT_W (MANT_W)
        ) u_lane_mask (
            .active (in_mask[i]),
            .sign   (in_sign[i]),
            .exp    (in_exp[i*EXP_W +: EXP_W]),
            .mant   (in_mant[i*MANT_W +: MANT_W]),
            .ov     (in_ov[i]),
            .sign_m (cap_sign[i]),
            .exp_m  (cap_exp[i*EXP_W +: EXP_W]),
            .mant_m (cap_mant[i*MANT_W +: MANT_W]),
            .ov_m   (cap_ov[i])
        );
    end

    assign cap_pay = {in_mask, cap_sign, cap_ov, cap_exp, cap_mant};

    fpm_stage_state_t state, next_state;
    logic [PAY_W-1:0] main_q;
    logic [PAY_W-1:0] skid_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic push, pop;
    logic load_main, load_skid, move_skid, clear;

    assign push = in_valid & in_ready_q;
    assign pop  = out_valid_q & out_ready;

    always_comb begin
        next_state = state;
        load_main  = 1'b0;
        load_skid  = 1'b0;
        move_skid  = 1'b0;
        clear      = 1'b0;
        unique case (state)
            EMPTY: begin
                if (push) begin
                    load_main  = 1'b1;
                    next_state = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    load_main = 1'b1;
                end else if (push) begin
                    load_skid  = 1'b1;
                    next_state = TWO;
                end else if (pop) begin
                    next_state = EMPTY;
                end
            end
            TWO: begin
                // in_ready is low here, so only a pop can change anything.
                if (pop) begin
                    move_skid  = 1'b1;
                    next_state = ONE;
                end
            end
            default: begin
                next_state = EMPTY;
                clear      = 1'b1;
            end
        endcase
`ifdef FPM_PIPE_FLUSH_EN
        // Flush wins over any concurrent push or pop; the incoming beat is dropped.
        if (flush) begin
            next_state = EMPTY;
            load_main  = 1'b0;
            load_skid  = 1'b0;
            move_skid  = 1'b0;
            clear      = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state       <= next_state;
            // Both handshake outputs come from flops, so out_ready never reaches in_ready.
            in_ready_q  <= (next_state != TWO);
            out_valid_q <= (next_state != EMPTY);
            if (clear) begin
                main_q <= '0;
                skid_q <= '0;
            end else begin
                if (load_main) begin
                    main_q <= cap_pay;
                end else if (move_skid) begin
                    main_q <= skid_q;
                end
                if (load_skid) begin
                    skid_q <= cap_pay;
                end
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign occupancy = state;
    assign {out_mask, out_sign, out_ov, out_exp, out_mant} = main_q;

endmodule

// File: tb/tb_fpm_pipe_stage.sv
// tb/tb_fpm_pipe_stage.sv - randomized self-checking bench for fpm_pipe_stage against a queue model
module tb_fpm_pipe_stage;

    localparam int LANES  = 4;
    localparam int EXP_W  = 9;
    localparam int MANT_W = 48;

    typedef struct packed {
        logic [LANES-1:0]        mask;
        logic [LANES-1:0]        sign;
        logic [LANES-1:0]        ov;
        logic [LANES*EXP_W-1:0]  exp;
        logic [LANES*MANT_W-1:0] mant;
    } beat_t;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES-1:0]        in_mask;
    logic [LANES-1:0]        in_sign;
    logic [LANES*EXP_W-1:0]  in_exp;
    logic [LANES*MANT_W-1:0] in_mant;
    logic [LANES-1:0]        in_ov;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES-1:0]        out_mask;
    logic [LANES-1:0]        out_sign;
    logic [LANES*EXP_W-1:0]  out_exp;
    logic [LANES*MANT_W-1:0] out_mant;
    logic [LANES-1:0]        out_ov;
    logic [1:0]              occupancy;
`ifdef FPM_PIPE_FLUSH_EN
    logic                    flush = 1'b0;
`endif

    fpm_pipe_stage #(.LANES(LANES), .EXP_W(EXP_W), .MANT_W(MANT_W)) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef FPM_PIPE_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mask   (in_mask),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .in_ov     (in_ov),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mask  (out_mask),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_mant  (out_mant),
        .out_ov    (out_ov),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    int    checks   = 0;
    int    failures = 0;
    int    pop_count = 0;
    beat_t model_q[$];
    beat_t cur;
    beat_t out_bus;

    assign out_bus = {out_mask, out_sign, out_ov, out_exp, out_mant};

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t rand_beat();
        beat_t b;
        b.mask = 4'($urandom);
        b.sign = 4'($urandom);
        b.ov   = 4'($urandom);
        b.exp  = {$urandom, $urandom};
        b.mant = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return b;
    endfunction

    // Inactive lanes are stored as all-zero; the mask itself travels unchanged.
    function automatic beat_t apply_mask(input beat_t b);
        beat_t r = b;
        for (int i = 0; i < LANES; i++) begin
            if (!b.mask[i]) begin
                r.sign[i] = 1'b0;
                r.ov[i]   = 1'b0;
                r.exp[i*EXP_W +: EXP_W]    = '0;
                r.mant[i*MANT_W +: MANT_W] = '0;
            end
        end
        return r;
    endfunction

    task automatic drive(input beat_t b, input logic v);
        cur      = b;
        in_valid = v;
        in_mask  = b.mask;
        in_sign  = b.sign;
        in_ov    = b.ov;
        in_exp   = b.exp;
        in_mant  = b.mant;
    endtask

    task automatic compare_model();
        check("occupancy", 256'(occupancy), 256'(model_q.size()));
        check("out_valid", 256'(out_valid), 256'(model_q.size() != 0));
        check("in_ready", 256'(in_ready), 256'(model_q.size() < 2));
        if (model_q.size() != 0) check("payload", 256'(out_bus), 256'(model_q[0]));
    endtask

    // One clock: decide the handshake from pre-edge values, advance the FIFO model, compare.
    task automatic step();
        bit push, pop, fl;
        push = in_valid && in_ready;
        pop  = out_valid && out_ready;
        fl   = 1'b0;
`ifdef FPM_PIPE_FLUSH_EN
        fl = flush;
`endif
        @(posedge clk);
        #1;
        if (fl) begin
            model_q.delete();
        end else begin
            if (pop) begin
                void'(model_q.pop_front());
                pop_count++;
            end
            if (push) model_q.push_back(apply_mask(cur));
        end
        compare_model();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_occ"}, 256'(occupancy), 256'(0));
        check({tag, "_valid"}, 256'(out_valid), 256'(0));
        check({tag, "_ready"}, 256'(in_ready), 256'(1));
        check({tag, "_payload"}, 256'(out_bus), 256'(0));
    endtask

    initial begin
        beat_t b;
        int    base;
        bit    ready_dropped;

        // Reset with garbage on every input.
        reset     = 1'b0;
        out_ready = 1'($urandom);
        drive(rand_beat(), 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        drive(rand_beat(), 1'b0);
        reset = 1'b1;
        step();
        check_reset_outputs("post_reset");

        // Single beat with out_ready high: visible one edge later.
        b = rand_beat();
        b.mask = 4'b1111;
        b.sign[0] = 1'b1;
        b.exp[8:0] = 9'h07F;
        b.mant[47:0] = 48'h800000000000;
        out_ready = 1'b1;
        drive(b, 1'b1);
        step();
        drive(rand_beat(), 1'b0);
        check("single_occ", 256'(occupancy), 256'(1));
        check("single_exp0", 256'(out_exp[8:0]), 256'(9'h07F));
        check("single_mant0", 256'(out_mant[47:0]), 256'(48'h800000000000));
        check("single_sign0", 256'(out_sign[0]), 256'(1));
        step();
        step();

        // Back-pressure: A and B fill the stage, C must wait upstream.
        out_ready = 1'b0;
        base = pop_count;
        drive(rand_beat(), 1'b1); step();
        drive(rand_beat(), 1'b1); step();
        check("bp_occ", 256'(occupancy), 256'(2));
        check("bp_ready", 256'(in_ready), 256'(0));
        drive(rand_beat(), 1'b1);
        step(); step();
        check("bp_hold_occ", 256'(occupancy), 256'(2));
        out_ready = 1'b1;
        for (int i = 0; i < 10 && model_q.size() != 0 || i < 10 && in_valid; i++) begin
            if (in_valid && in_ready) begin
                step();
                drive(rand_beat(), 1'b0);
            end else begin
                step();
            end
        end
        check("bp_drain_count", 256'(pop_count - base), 256'(3));

        // Streaming with an incrementing exponent.
        base = pop_count;
        ready_dropped = 1'b0;
        for (int k = 0; k < 100; k++) begin
            b = rand_beat();
            b.mask = 4'b1111;
            b.exp[8:0] = 9'(k);
            drive(b, 1'b1);
            if (!in_ready) ready_dropped = 1'b1;
            step();
        end
        drive(rand_beat(), 1'b0);
        for (int i = 0; i < 4 && model_q.size() != 0; i++) step();
        check("stream_count", 256'(pop_count - base), 256'(100));
        check("stream_ready_high", 256'(ready_dropped), 256'(0));

        // Lane masking.
        b.mask = 4'b0101;
        b.sign = 4'b1111;
        b.ov   = 4'b1111;
        b.exp  = {4{9'h1FF}};
        b.mant = {4{48'hABCDEF012345}};
        out_ready = 1'b0;
        drive(b, 1'b1);
        step();
        drive(rand_beat(), 1'b0);
        check("mask_mask", 256'(out_mask), 256'(4'b0101));
        check("mask_ov", 256'(out_ov), 256'(4'b0101));
        check("mask_sign", 256'(out_sign), 256'(4'b0101));
        check("mask_exp", 256'(out_exp), 256'({9'h0, 9'h1FF, 9'h0, 9'h1FF}));
        check("mask_mant", 256'(out_mant), 256'({48'h0, 48'hABCDEF012345, 48'h0, 48'hABCDEF012345}));
        out_ready = 1'b1;
        step();

        // Randomized traffic; upstream holds its beat while stalled.
        for (int k = 0; k < 400; k++) begin
            if (!(in_valid && !in_ready)) drive(rand_beat(), 1'($urandom_range(0, 3) != 0));
            out_ready = 1'($urandom_range(0, 2) != 0);
            step();
        end

        // Reset while two beats are held, with a beat offered alongside.
        drive(rand_beat(), 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 4 && model_q.size() != 0; i++) begin
            out_ready = 1'b1;
            step();
        end
        out_ready = 1'b0;
        drive(rand_beat(), 1'b1); step();
        drive(rand_beat(), 1'b1); step();
        check("rst2_pre_occ", 256'(occupancy), 256'(2));
        out_ready = 1'b1;
        reset = 1'b0;
        #1;
        model_q.delete();
        check_reset_outputs("async_reset");
        @(posedge clk);
        #1;
        drive(rand_beat(), 1'b0);
        reset = 1'b1;
        step();
        check_reset_outputs("rst2_after");

`ifdef FPM_PIPE_FLUSH_EN
        // Flush with two beats held and a beat offered.
        out_ready = 1'b0;
        drive(rand_beat(), 1'b1); step();
        drive(rand_beat(), 1'b1); step();
        check("flush_pre_occ", 256'(occupancy), 256'(2));
        out_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(rand_beat(), 1'b0);
        check_reset_outputs("flush_two");
        // Flush with one beat held while a push and pop coincide.
        drive(rand_beat(), 1'b1); step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(rand_beat(), 1'b0);
        check_reset_outputs("flush_one");
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpm_pipe_stage.md
Name: fpm_pipe_stage

Overview:
- Parametrised elastic pipeline register between stages of the vector floating-point multiplier.
- Carries, per lane: sign, biased exponent, normalised mantissa product and overflow flag.
- Replaces fixed-width, always-enabled stage registers with a valid/ready handshake and a 2-entry skid buffer. Back-pressure is therefore fully registered and timing-isolated.
- Supports LANES parallel lanes sharing one handshake, with a per-lane active mask.

Parameters:
- LANES, 4, number of vector lanes sharing one handshake.
- EXP_W, 9, exponent width per lane (biased exponent plus one overflow guard bit).
- MANT_W, 48, mantissa product width per lane.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat; registered output.
- in_mask  in  LANES  lane-active bits.
- in_sign  in  LANES  sign per lane.
- in_exp  in  LANES*EXP_W  exponent per lane; lane i occupies bits [i*EXP_W +: EXP_W].
- in_mant  in  LANES*MANT_W  mantissa per lane; lane i occupies bits [i*MANT_W +: MANT_W].
- in_ov  in  LANES  overflow flag per lane.
- out_valid  out  1  downstream beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_mask, out_sign, out_exp, out_mant, out_ov  out  same widths as inputs  registered payload.
- occupancy  out  2  number of held beats (0..2).

Behaviour:
- Clock and reset: reset is asynchronous, active-low; clk is the clock. All state is in flops on the rising edge of clk.
- Reset values: out_valid=0, in_ready=1, occupancy=0, and every payload output 0. The skid register is also cleared.
- Storage: main register (drives out_*) plus a skid register.
- States: EMPTY (occ 0), ONE (main valid), TWO (main and skid valid).
- Handshake definitions:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Transitions:
  - EMPTY: push -> load main, go to ONE.
  - ONE:
    - push & pop -> load main, stay in ONE.
    - push & !pop -> load skid, go to TWO.
    - !push & pop -> go to EMPTY.
  - TWO:
    - pop -> move skid to main, go to ONE.
    - push is impossible in TWO, since in_ready=0.
- in_ready is the registered value of (next_state != TWO). It never depends combinationally on out_ready.
- out_valid = (state != EMPTY), registered.
- Latency and throughput:
  - Latency is 1 cycle from push to out_valid when the stage is EMPTY or popping.
  - Sustained throughput is 1 beat per cycle.
  - Beat order is strictly preserved.
- Payload stability: while out_valid=1 and out_ready=0, all out_* hold stable.
- Lane masking: on capture, any lane with in_mask[i]=0 stores sign=0, exp=0, mant=0, ov=0. The mask itself is stored unchanged.
- An all-zero mask is a legal beat and is passed through.
- in_valid=1 while in_ready=0 is ignored; the upstream stage must hold its data.
- Reset mid-operation: asserting reset discards both held beats immediately. All outputs take their reset values asynchronously.
- No arithmetic is performed; widths pass through unchanged.

Optional Feature:
- Macro: FPM_PIPE_FLUSH_EN.
- With the macro defined:
  - Adds input port flush (1 bit), synchronous and active-high.
  - When flush=1 at a clock edge: state goes to EMPTY, occupancy=0, out_valid=0, in_ready=1 on the next cycle, and the payload is zeroed.
  - Flush has priority over a simultaneous push or pop; the concurrent input beat is dropped.
- Without the macro: the flush port does not exist, and the stage is cleared only by reset.

Decomposition:
- Shared package fpm_pkg holds:
  - default widths FPM_EXP_W=9, FPM_MANT_W=48, FPM_LANES=4;
  - the state encoding typedef fpm_stage_state_t {EMPTY, ONE, TWO}.
- One natural sub-module, fpm_lane_mask. It is combinational: it zeroes the payload of inactive lanes and is instantiated once per lane by a generate loop.
- The skid control logic stays in the top module.

Test Plan:
- Reset with garbage on inputs: hold reset low for 3 cycles -> out_valid=0, in_ready=1, occupancy=0, all outputs 0.
- Single beat, out_ready=1: push mask=4'b1111, lane0 exp=9'h07F, mant=48'h800000000000, sign=1 -> that value on out_* exactly 1 cycle later, with occupancy=1.
- Back-pressure: out_ready=0, push beats A, B, then C -> occupancy=2 and in_ready=0 after B. C is held upstream. Release out_ready -> A, B, C appear in order with no loss or duplication.
- Streaming: out_ready=1, 100 consecutive beats with an incrementing exponent -> 100 outputs, in_ready stays 1 throughout, order preserved.
- Masking: mask=4'b0101 with all lanes at exp=9'h1FF and ov=1 -> out lanes 1 and 3 are all-zero, lanes 0 and 2 pass unchanged, out_mask=4'b0101.
- Reset while occupancy=2 (and flush while occupancy=2 when FPM_PIPE_FLUSH_EN is defined) -> next cycle occupancy=0, out_valid=0, in_ready=1, and the beat pushed in the same cycle is dropped.
